// File: rtl/ieee64_trace_reader.sv
// Frame capture and valid/ready readout of NCH 64-bit model channels.
// Optional header beat {seq, ts} and 48-bit timestamp under `TRACE_TIMESTAMP_EN.
module ieee64_trace_reader #(
  parameter int NCH = 4
) (
  input  logic              clk_0_1ps,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_tick,
  input  logic [NCH*64-1:0] ch_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_data,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       overflow_cnt
);

  localparam int            IW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);
  localparam logic          ONE_CH   = (NCH == 1);

`ifdef TRACE_TIMESTAMP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd2} state_t;
`endif

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, idx_n;
  logic [15:0]   seq_q, seq_d;
  logic [15:0]   ovf_q, ovf_d;
  logic          pend_full_q, pend_full_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          busy_q, busy_d;
  logic [63:0]   out_data_q, out_data_d;

  logic [63:0]   ch_in    [NCH];
  logic [63:0]   pend_ch_q[NCH];
  logic [63:0]   act_ch_q [NCH];

`ifdef TRACE_TIMESTAMP_EN
  logic [47:0]   ts_q, ts_d;
  logic [47:0]   pend_ts_q;
  logic [15:0]   pend_seq_q;
  logic [63:0]   nf_hdr;
`endif

  logic          hs, frame_done, load_slot, tick_en;
  logic          pend_frees, cap, drop, direct, load_act;
  logic [63:0]   nf_ch0;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_unpack
      assign ch_in[gi] = ch_data[64*gi +: 64];
    end
  endgenerate

  // Admission: the pending slot counts as free when it hands its frame over on this edge.
  // With nothing pending, a capture at a load point bypasses pending and goes straight to active.
  always_comb begin
    hs          = out_valid_q && out_ready;
    frame_done  = hs && (state_q == DATA) && (idx_q == LAST_IDX);
    load_slot   = (state_q == IDLE) || frame_done;
    tick_en     = sample_tick && enable;
    pend_frees  = load_slot && pend_full_q;
    cap         = tick_en && (!pend_full_q || pend_frees);
    drop        = tick_en && !cap;
    direct      = cap && load_slot && !pend_full_q;
    load_act    = pend_frees || direct;
    pend_full_d = (cap && !direct) || (pend_full_q && !pend_frees);
    seq_d       = cap ? seq_q + 16'd1 : seq_q;
    ovf_d       = (drop && (ovf_q != 16'hFFFF)) ? ovf_q + 16'd1 : ovf_q;
    nf_ch0      = pend_frees ? pend_ch_q[0] : ch_in[0];
    idx_n       = idx_q + IW'(1);
`ifdef TRACE_TIMESTAMP_EN
    ts_d        = ts_q + 48'd1;
    nf_hdr      = pend_frees ? {pend_seq_q, pend_ts_q} : {seq_q, ts_q};
`endif
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (load_slot) begin
      if (load_act) begin
        out_valid_d = 1'b1;
        idx_d       = '0;
`ifdef TRACE_TIMESTAMP_EN
        state_d     = HDR;
        out_data_d  = nf_hdr;
        out_last_d  = 1'b0;
`else
        state_d     = DATA;
        out_data_d  = nf_ch0;
        out_last_d  = ONE_CH;
`endif
      end else begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_last_d  = 1'b0;
      end
    end else if (hs) begin
      case (state_q)
`ifdef TRACE_TIMESTAMP_EN
        HDR: begin
          state_d    = DATA;
          idx_d      = '0;
          out_data_d = act_ch_q[0];
          out_last_d = ONE_CH;
        end
`endif
        DATA: begin
          idx_d      = idx_n;
          out_data_d = act_ch_q[idx_n];
          out_last_d = (idx_n == LAST_IDX);
        end
        default: ;
      endcase
    end
    busy_d = (state_d != IDLE) || pend_full_d;
  end

  always_ff @(posedge clk_0_1ps or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      seq_q       <= '0;
      ovf_q       <= '0;
      pend_full_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef TRACE_TIMESTAMP_EN
      ts_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      seq_q       <= seq_d;
      ovf_q       <= ovf_d;
      pend_full_q <= pend_full_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
`ifdef TRACE_TIMESTAMP_EN
      ts_q        <= ts_d;
`endif
    end
  end

  // Buffer payloads need no reset; validity lives in pend_full_q and state_q.
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_buf
      always_ff @(posedge clk_0_1ps) begin
        if (cap && !direct) pend_ch_q[gi] <= ch_in[gi];
        if (load_act)       act_ch_q[gi]  <= pend_frees ? pend_ch_q[gi] : ch_in[gi];
      end
    end
  endgenerate

`ifdef TRACE_TIMESTAMP_EN
  always_ff @(posedge clk_0_1ps) begin
    if (cap && !direct) begin
      pend_seq_q <= seq_q;
      pend_ts_q  <= ts_q;
    end
  end
`endif

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign busy         = busy_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: doc/ieee64_trace_reader.md
# ieee64_trace_reader

Capture and readout block for the IEEE-754 double-precision synapse/neuron model outputs. On each qualified sample tick it snapshots NCH 64-bit channels (Isyn1, WWx, Ax, Dx and similar) with a cycle timestamp and sequence number. It then streams each frame out as 64-bit words over a valid/ready interface. It sits beside top64, runs in the clk_0_1ps domain, and consumes the model outputs where the stimulus side produces tp1/td4.

## Interface
- NCH, 4: number of 64-bit channels captured per frame (1..16)
- clk_0_1ps  input  1  single clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- enable  input  1  capture qualifier; sample_tick ignored while low
- sample_tick  input  1  one-cycle capture request (upstream edge-detected slow-clock pulse)
- ch_data  input  NCH*64  channel bus; channel i = ch_data[64*i +: 64]
- out_valid  output  1  out_data/out_last hold a valid beat
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready
- out_data  output  64  header or channel word
- out_last  output  1  marks the final word of a frame
- busy  output  1  frame in flight or pending
- overflow_cnt  output  16  dropped sample count, saturating

## Operation
- Two frame buffers: pending (snapshot) and active (being streamed).
- Capture: sample_tick && enable && pending slot free (or freeing this cycle) → latch ch_data, ts_cnt, seq into pending; seq += 1 (16-bit, wraps 0xFFFF→0).
- Drop: sample_tick && enable && pending full and not draining this cycle → no capture, seq unchanged, overflow_cnt += 1, saturating at 0xFFFF.
- ts_cnt: 48-bit free-running counter, cleared by reset, increments every cycle, wraps.
- FSM states: IDLE, HDR, DATA.
  - IDLE: if pending full, move pending→active and enter HDR.
  - HDR: out_data = {seq[15:0], ts[47:0]}. On handshake, go to DATA with idx=0.
  - DATA: out_data = channel idx; out_last = (idx==NCH-1). On handshake, idx += 1. After the last handshake: if pending full, transfer it and go to HDR; else go to IDLE.
- out_data, out_last and out_valid are stable while out_valid && !out_ready.
- enable deasserting mid-frame: the frame in flight and the pending frame both complete.
- busy = (state != IDLE) || pending full.

## Timing
- Reset values: out_valid 0, out_data 0, out_last 0, busy 0, overflow_cnt 0, seq 0, ts_cnt 0, state IDLE, both buffers empty.
- All outputs are registered.
- Latency: a capture in cycle t with the engine idle gives a header on out_data with out_valid=1 in cycle t+1.
- Throughput: one word per cycle with out_ready held high. A frame is NCH+1 beats.
- Back-to-back frames: if pending is full at the last handshake (cycle k), the next header is valid in cycle k+1 with no bubble.
- Simultaneous pending→active transfer and sample_tick in the same cycle: the capture is accepted, not counted as overflow.
- Reset asserted mid-frame: out_valid drops asynchronously. Both buffers are discarded. Counters clear.

## Configuration
- TRACE_TIMESTAMP_EN defined: ts_cnt and the header beat are present. A frame is NCH+1 beats, as above.
- Not defined: ts_cnt and the HDR state are removed. A frame is NCH beats and the first beat is channel 0. seq is still maintained internally, and overflow behaviour is unchanged.

## Test plan
- Reset release, NCH=4, out_ready=1, one sample_tick at cycle 10 with ch0..3 = 0x3FF0000000000000, 0x4000000000000000, 0xBFF0000000000000, 0x0:
  - cycles 11..15 emit header {16'h0000, ts=10}, then the four words; out_last only at cycle 15.
- Backpressure: out_ready low for 3 cycles during the DATA beat idx=1 → out_data holds 0x4000000000000000 and out_valid stays 1; no beat is lost or duplicated.
- Overflow: out_ready=0, three sample_ticks → first goes active, second goes pending, third is dropped; overflow_cnt=1.
  - With out_ready=1, two frames stream with seq 0 and 1, back-to-back.
- enable=0 with sample_tick pulses → no out_valid, seq and overflow_cnt unchanged. Drop enable mid-frame → the frame finishes.
- Reset asserted at the DATA beat idx=2 → out_valid=0 in the same cycle; after release, the next capture yields header seq 0.
- Seq wrap: 65537 accepted captures → the last header has seq 0x0000.
- With TRACE_TIMESTAMP_EN undefined → a frame is exactly 4 beats with no header.
